arbitro_ram: RTL and testbench

ARBITRO_RAM -- requirements
Module: arbitro_ram

---
 rtl/arbitro_ram.sv | 137 +++++++++++++
 tb/tb_arbitro_ram.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_ram.sv
// arbitro_ram: two-requester arbiter in front of a single-port RAM.
// One transaction runs through IDLE -> ACCESS -> DONE. Simultaneous
// requests are resolved by a 1-bit round-robin pointer, which is flipped
// to the loser each time a transaction completes its access.
module arbitro_ram #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         a_req_i,
  input  logic         b_req_i,
  input  logic         a_we_i,
  input  logic         b_we_i,
  input  logic [N-1:0] a_addr_i,
  input  logic [N-1:0] b_addr_i,
  input  logic [M-1:0] a_dato_i,
  input  logic [M-1:0] b_dato_i,
  output logic         a_ack_o,
  output logic         b_ack_o,
  output logic [M-1:0] a_dato_o,
  output logic [M-1:0] b_dato_o,
  output logic [N-1:0] ram_addr_o,
  output logic         ram_rden_o,
  output logic         ram_wren_o,
  output logic [M-1:0] ram_dato_write_o,
  input  logic [M-1:0] ram_dato_read_i,
  output logic         busy_o,
  output logic [7:0]   cnt_a_o,
  output logic [7:0]   cnt_b_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Latched request of the winner; requester inputs are ignored after grant.
  typedef struct packed {
    logic         we;
    logic [N-1:0] addr;
    logic [M-1:0] dato;
  } req_t;

  logic [1:0]   state_q, state_d;
  logic         ptr_q;    // 0 = A has priority, 1 = B
  logic         win_q;    // 0 = A owns the current transaction, 1 = B
  req_t         lat_q;
  req_t         a_req_s, b_req_s;
  logic         any_req, grant_b;
  logic         in_access, in_done;
  logic [M-1:0] a_dato_q, b_dato_q;
  logic [7:0]   cnt_a_q, cnt_b_q;

  assign a_req_s = '{we: a_we_i, addr: a_addr_i, dato: a_dato_i};
  assign b_req_s = '{we: b_we_i, addr: b_addr_i, dato: b_dato_i};

  // Grant decision: B wins if it is alone or if it holds the pointer.
  always_comb begin
    any_req = a_req_i | b_req_i;
    grant_b = b_req_i & (~a_req_i | ptr_q);
  end

  // Next-state logic; ACCESS and DONE each last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; async reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture winner and its request on the IDLE->ACCESS edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_q <= 1'b0;
      lat_q <= '0;
    end else if (state_q == ST_IDLE && any_req) begin
      win_q <= grant_b;
      lat_q <= grant_b ? b_req_s : a_req_s;
    end
  end

  // Pointer moves to the non-winner once the access has happened.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                  ptr_q <= 1'b0;
    else if (state_q == ST_ACCESS) ptr_q <= ~win_q;
  end

  // Read data lands only in the winner's register, held until its next read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_dato_q <= '0;
      b_dato_q <= '0;
    end else if (state_q == ST_ACCESS && !lat_q.we) begin
      if (win_q) b_dato_q <= ram_dato_read_i;
      else       a_dato_q <= ram_dato_read_i;
    end
  end

  // Completed-transaction counters, bumped on the ack cycle, saturating.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (!win_q && cnt_a_q != 8'hFF) cnt_a_q <= cnt_a_q + 8'd1;
      if ( win_q && cnt_b_q != 8'hFF) cnt_b_q <= cnt_b_q + 8'd1;
    end
  end

  // RAM strobes and acks decode straight from state so reset kills them at once.
  always_comb begin
    in_access        = (state_q == ST_ACCESS);
    in_done          = (state_q == ST_DONE);
    ram_addr_o       = in_access ? lat_q.addr : '0;
    ram_dato_write_o = in_access ? lat_q.dato : '0;
    ram_wren_o       = in_access &  lat_q.we;
    ram_rden_o       = in_access & ~lat_q.we;
    a_ack_o          = in_done & ~win_q;
    b_ack_o          = in_done &  win_q;
    busy_o           = (state_q != ST_IDLE);
  end

  assign a_dato_o = a_dato_q;
  assign b_dato_o = b_dato_q;
  assign cnt_a_o  = cnt_a_q;
  assign cnt_b_o  = cnt_b_q;

endmodule

// File: tb/tb_arbitro_ram.sv
// Directed bench for arbitro_ram with a tiny RAM model and an ack scoreboard.
module tb_arbitro_ram;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       a_req_i, b_req_i, a_we_i, b_we_i;
  logic [3:0] a_addr_i, b_addr_i, a_dato_i, b_dato_i;
  logic       a_ack_o, b_ack_o;
  logic [3:0] a_dato_o, b_dato_o;
  logic [3:0] ram_addr_o, ram_dato_write_o, ram_dato_read_i;
  logic       ram_rden_o, ram_wren_o, busy_o;
  logic [7:0] cnt_a_o, cnt_b_o;

  arbitro_ram #(.N(4), .M(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .a_req_i(a_req_i), .b_req_i(b_req_i),
    .a_we_i(a_we_i), .b_we_i(b_we_i),
    .a_addr_i(a_addr_i), .b_addr_i(b_addr_i),
    .a_dato_i(a_dato_i), .b_dato_i(b_dato_i),
    .a_ack_o(a_ack_o), .b_ack_o(b_ack_o),
    .a_dato_o(a_dato_o), .b_dato_o(b_dato_o),
    .ram_addr_o(ram_addr_o), .ram_rden_o(ram_rden_o), .ram_wren_o(ram_wren_o),
    .ram_dato_write_o(ram_dato_write_o), .ram_dato_read_i(ram_dato_read_i),
    .busy_o(busy_o), .cnt_a_o(cnt_a_o), .cnt_b_o(cnt_b_o)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read.
  logic [3:0] mem [0:15];
  always @(posedge clk) if (ram_wren_o) mem[ram_addr_o] <= ram_dato_write_o;
  assign ram_dato_read_i = mem[ram_addr_o];

  typedef struct { logic who; logic we; logic [3:0] data; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, acks = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard whenever an ack shows up.
  task automatic monitor();
    exp_t e;
    if (a_ack_o || b_ack_o) begin
      check("ack_onehot", a_ack_o & b_ack_o, 0);
      if (sb.size() == 0) begin
        tests++; fails++;
        $error("FAIL unexpected_ack observed a=%0b b=%0b expected none", a_ack_o, b_ack_o);
      end else begin
        e = sb.pop_front();
        check("ack_who", b_ack_o, e.who);
        if (!e.we) check("rd_data", e.who ? b_dato_o : a_dato_o, e.data);
        acks++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until(int target, int budget);
    int n = 0;
    while (acks < target && n < budget) begin tick(); n++; end
    a_req_i = 1'b0;
    b_req_i = 1'b0;
    if (acks < target) begin
      tests++; fails++;
      $error("FAIL timeout observed acks=%0d expected=%0d", acks, target);
    end
  endtask

  initial begin
    int target;
    rst_i = 1'b0;
    a_req_i = 0; b_req_i = 0; a_we_i = 0; b_we_i = 0;
    a_addr_i = 0; b_addr_i = 0; a_dato_i = 0; b_dato_i = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_wren", ram_wren_o, 0);
    check("rst_rden", ram_rden_o, 0);
    check("rst_addr", ram_addr_o, 0);
    check("rst_wdata", ram_dato_write_o, 0);
    check("rst_acks", {a_ack_o, b_ack_o}, 0);
    check("rst_cnt", {cnt_a_o, cnt_b_o}, 0);
    check("rst_dato", {a_dato_o, b_dato_o}, 0);
    rst_i = 1'b1;

    // A writes 0xA to addr 3
    a_req_i = 1; a_we_i = 1; a_addr_i = 3; a_dato_i = 4'hA;
    sb.push_back('{1'b0, 1'b1, 4'hA});
    tick();
    check("wr_wren", ram_wren_o, 1);
    check("wr_rden", ram_rden_o, 0);
    check("wr_addr", ram_addr_o, 3);
    check("wr_wdata", ram_dato_write_o, 4'hA);
    check("wr_busy", busy_o, 1);
    check("wr_noack_early", a_ack_o, 0);
    a_req_i = 0;
    tick();
    check("wr_ack", a_ack_o, 1);
    check("wr_wren_done", ram_wren_o, 0);
    tick();
    check("wr_cnt_a", cnt_a_o, 1);
    check("wr_idle", busy_o, 0);
    check("wr_ack_single", a_ack_o, 0);

    // A reads back addr 3
    a_req_i = 1; a_we_i = 0; a_addr_i = 3;
    sb.push_back('{1'b0, 1'b0, 4'hA});
    tick();
    check("rd_rden", ram_rden_o, 1);
    check("rd_wren", ram_wren_o, 0);
    check("rd_addr", ram_addr_o, 3);
    a_req_i = 0;
    tick();
    check("rd_a_dato_ack", a_dato_o, 4'hA);
    check("rd_b_dato", b_dato_o, 0);
    tick();
    check("rd_a_dato_hold", a_dato_o, 4'hA);
    check("rd_cnt_a", cnt_a_o, 2);

    // B pulses req only while A holds the grant
    a_req_i = 1; a_we_i = 1; a_addr_i = 5; a_dato_i = 4'h7;
    sb.push_back('{1'b0, 1'b1, 4'h7});
    tick();
    a_req_i = 0; b_req_i = 1; b_we_i = 1; b_addr_i = 6; b_dato_i = 4'h3;
    tick();
    b_req_i = 0;
    check("pulse_b_ack", b_ack_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pulse_no_access", {ram_wren_o, ram_rden_o, b_ack_o}, 0);
    end
    check("pulse_cnt_b", cnt_b_o, 0);
    check("pulse_cnt_a", cnt_a_o, 3);

    // Fresh reset, then both requesters held for 6 transactions
    rst_i = 0;
    @(negedge clk);
    rst_i = 1;
    a_req_i = 1; a_we_i = 1; a_addr_i = 1; a_dato_i = 4'h1;
    b_req_i = 1; b_we_i = 1; b_addr_i = 2; b_dato_i = 4'h2;
    for (int i = 0; i < 6; i++) sb.push_back('{i[0], 1'b1, 4'h0});
    target = acks + 6;
    run_until(target, 40);
    tick();
    check("rr_cnt_a", cnt_a_o, 3);
    check("rr_cnt_b", cnt_b_o, 3);
    check("rr_mem1", mem[1], 1);
    check("rr_mem2", mem[2], 2);

    // Reset during ACCESS of a B write
    b_req_i = 1; b_we_i = 1; b_addr_i = 9; b_dato_i = 4'h5;
    tick();
    check("abort_wren_pre", ram_wren_o, 1);
    b_req_i = 0;
    #2 rst_i = 0;
    #1;
    check("abort_wren", ram_wren_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_b_ack", b_ack_o, 0);
    @(negedge clk);
    check("abort_cnt_b", cnt_b_o, 0);
    rst_i = 1;
    repeat (3) tick();
    check("abort_idle", busy_o, 0);

    // 300 back-to-back A reads: counter saturates
    a_req_i = 1; a_we_i = 0; a_addr_i = 1;
    for (int i = 0; i < 300; i++) sb.push_back('{1'b0, 1'b0, 4'h1});
    target = acks + 300;
    run_until(target, 1000);
    tick();
    check("sat_cnt_a", cnt_a_o, 255);
    repeat (3) tick();
    check("sat_cnt_hold", cnt_a_o, 255);
    check("sat_cnt_b", cnt_b_o, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
